// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency, byte-addressable word memory behind
// an IDLE/WAIT/RESP handshake that stalls the pipeline while an access is in flight.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   req_valid           - MEM stage presents an access (held while stall=1)
//   req_we              - 1 = store, 0 = load
//   req_size            - 00 word, 01 halfword, 10 byte, 11 illegal
//   req_unsigned        - 1 = zero-extend load, 0 = sign-extend
//   req_addr            - byte address (wraps modulo DEPTH_WORDS*4)
//   req_wdata           - right-aligned store data
//   stall               - freeze PC and upstream pipeline registers
//   resp_valid          - one-cycle completion pulse
//   rdata               - extended load data, valid with resp_valid
//   resp_err            - misaligned / illegal-size flag, valid with resp_valid
module dmem_responder #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_err_q, resp_err_d;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [AW-1:0]  idx;
    logic           commit;
    logic           misalign;
    logic           mem_we;
    logic [3:0]     be;
    logic [31:0]    wword;
    logic [31:0]    rword;
    logic [31:0]    shifted;
    logic [31:0]    load_val;

    // Upper address bits are intentionally dropped (address wrap).
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW+2];

    // Access datapath, driven from the latched request.
    always_comb begin
        idx      = addr_q[AW+1:2];
        commit   = (state_q == WAIT) && (cnt_q == 4'd0);
        misalign = (size_q == 2'b11)
                || ((size_q == 2'b00) && (addr_q[1:0] != 2'b00))
                || ((size_q == 2'b01) && addr_q[0]);
        be       = 4'b0000;
        wword    = wdata_q;
        case (size_q)
            2'b00: be = 4'b1111;
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be    = 4'b0001 << addr_q[1:0];
                wword = {4{wdata_q[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        mem_we   = commit && we_q && !misalign;

        rword    = mem[idx];
        shifted  = rword >> {addr_q[1:0], 3'b000};
        load_val = 32'd0;
        case (size_q)
            2'b00: load_val = rword;
            2'b01: load_val = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
            2'b10: load_val = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
            default: load_val = 32'd0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = 32'd0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = misalign;
                    rdata_d      = (we_q || misalign) ? 32'd0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory is not reset; reset only suppresses an in-flight commit.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wword[8*k +: 8];
                end
            end
        end
    end

    assign stall      = !rst && (((state_q == IDLE) && req_valid)
                                 || (state_q == WAIT));
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of accesses with expected
// response, checked for data, error flag, stall window and latency.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .LATENCY     (LAT),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .rdata        (rdata),
        .resp_err     (resp_err)
    );

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic we,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.nm = nm; v.we = we; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Called just after a rising edge with the DUT in IDLE; returns just
    // after the edge that ends the RESP cycle, with req_valid still high.
    task automatic access(input vec_t v);
        int  cyc;
        bit  got;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= int'(LAT) + 3) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                chk({v.nm, " latency"}, 32'(cyc), 32'(LAT + 1));
                chk({v.nm, " rdata"}, rdata, v.exp_rdata);
                chk({v.nm, " err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
                chk({v.nm, " stall_resp"}, {31'd0, stall}, 32'd0);
            end else if (cyc <= int'(LAT)) begin
                chk({v.nm, " stall"}, {31'd0, stall}, 32'd1);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s timeout: got no resp_valid expected one", v.nm);
        end
    endtask

    initial begin
        vecs.push_back(mk("sw10",   1, 2'b00, 0, 32'h10,   32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk("lw10",   0, 2'b00, 0, 32'h10,   32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("sw20",   1, 2'b00, 0, 32'h20,   32'h0, 32'h0, 0));
        vecs.push_back(mk("sb21",   1, 2'b10, 0, 32'h21,   32'hFFFFFF80, 32'h0, 0));
        vecs.push_back(mk("sb22",   1, 2'b10, 0, 32'h22,   32'h1234567F, 32'h0, 0));
        vecs.push_back(mk("lb21",   0, 2'b10, 0, 32'h21,   32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu21",  0, 2'b10, 1, 32'h21,   32'h0, 32'h00000080, 0));
        vecs.push_back(mk("lw20",   0, 2'b00, 1, 32'h20,   32'h0, 32'h007F8000, 0));
        vecs.push_back(mk("sw30",   1, 2'b00, 0, 32'h30,   32'h11223344, 32'h0, 0));
        vecs.push_back(mk("sh32",   1, 2'b01, 0, 32'h32,   32'h5A5AA5A5, 32'h0, 0));
        vecs.push_back(mk("lh32",   0, 2'b01, 0, 32'h32,   32'h0, 32'hFFFFA5A5, 0));
        vecs.push_back(mk("lhu32",  0, 2'b01, 1, 32'h32,   32'h0, 32'h0000A5A5, 0));
        vecs.push_back(mk("lh30",   0, 2'b01, 0, 32'h30,   32'h0, 32'h00003344, 0));
        vecs.push_back(mk("lw30",   0, 2'b00, 0, 32'h30,   32'h0, 32'hA5A53344, 0));
        vecs.push_back(mk("sw14",   1, 2'b00, 0, 32'h14,   32'h55667788, 32'h0, 0));
        vecs.push_back(mk("lw13e",  0, 2'b00, 0, 32'h13,   32'h0, 32'h0, 1));
        vecs.push_back(mk("sh15e",  1, 2'b01, 0, 32'h15,   32'h0000FFFF, 32'h0, 1));
        vecs.push_back(mk("ld11e",  0, 2'b11, 0, 32'h14,   32'h0, 32'h0, 1));
        vecs.push_back(mk("st11e",  1, 2'b11, 0, 32'h14,   32'h0, 32'h0, 1));
        vecs.push_back(mk("lw14",   0, 2'b00, 0, 32'h14,   32'h0, 32'h55667788, 0));
        vecs.push_back(mk("lb14",   0, 2'b10, 0, 32'h14,   32'h0, 32'hFFFFFF88, 0));
        vecs.push_back(mk("lbu17",  0, 2'b10, 1, 32'h17,   32'h0, 32'h00000055, 0));
        vecs.push_back(mk("sw1000", 1, 2'b00, 0, 32'h1000, 32'h12345678, 32'h0, 0));
        vecs.push_back(mk("lw0",    0, 2'b00, 0, 32'h0,    32'h0, 32'h12345678, 0));
        vecs.push_back(mk("sw40",   1, 2'b00, 0, 32'h40,   32'hCAFEF00D, 32'h0, 0));

        rst          = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst err", {31'd0, resp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Requests run back to back with req_valid held through RESP.
        foreach (vecs[i]) access(vecs[i]);

        // Reset in WAIT must drop the pending store and its response.
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h40;
        req_wdata = 32'h0BADBEEF;
        @(negedge clk);
        chk("rstw stall_t", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw stall_rst", {31'd0, stall}, 32'd0);
        chk("rstw resp_rst", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstw resp_after", {31'd0, resp_valid}, 32'd0);
            chk("rstw stall_after", {31'd0, stall}, 32'd0);
            @(posedge clk);
            #1;
        end
        access(mk("lw40", 0, 2'b00, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0));
        req_valid = 1'b0;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, SHALL set the wait-state count for each access; legal range is 1 to 15.
REQ-002 Parameter DEPTH_WORDS, default 1024, SHALL set the memory size in 32-bit words; it is a power of 2.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mean the MEM stage presents an access; it is held stable while stall=1.
REQ-006 req_we  in  1  SHALL select the access type: 1 = store, 0 = load.
REQ-007 req_size  in  2  SHALL encode the access size: 00 word, 01 halfword, 10 byte, 11 illegal.
REQ-008 req_unsigned  in  1  SHALL select load extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  in  32  SHALL be the byte address.
REQ-010 req_wdata  in  32  SHALL be the store data, right-aligned.
REQ-011 stall  out  1  SHALL tell the pipeline to freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-012 resp_valid  out  1  SHALL be a one-cycle pulse marking access completion.
REQ-013 rdata  out  32  SHALL carry the extended load data; it is valid only while resp_valid=1.
REQ-014 resp_err  out  1  SHALL flag a misaligned or illegal-size access; it is valid only while resp_valid=1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with req_valid=1, the block SHALL latch all req_* inputs at the clock edge, load cnt=LATENCY-1 and move to WAIT.
REQ-017 In WAIT, cnt SHALL decrement each cycle; when cnt=0, at that edge the block SHALL perform the access and move to RESP.
REQ-018 In RESP, resp_valid SHALL be 1 and the next state SHALL be IDLE unconditionally.
REQ-019 req_valid SHALL be ignored while in RESP, because that cycle still holds the request being retired.
REQ-020 stall SHALL equal (state==IDLE and req_valid) or (state==WAIT); stall SHALL be 0 in RESP.
REQ-021 Latency: with the request first seen in cycle T, resp_valid SHALL assert in cycle T+LATENCY+1; stall SHALL be high from T to T+LATENCY inclusive.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-023 Byte lanes SHALL be little-endian: byte k of a word occupies bits [8k+7:8k], and k=addr[1:0].
REQ-024 A word store SHALL write all 4 lanes.
REQ-025 A halfword store SHALL write wdata[15:0] to lanes {addr[1],0} and {addr[1],1} only.
REQ-026 A byte store SHALL write wdata[7:0] to lane addr[1:0] only.
REQ-027 The store commit and the load read SHALL occur at the same edge (end of WAIT with cnt=0); the load SHALL therefore see all prior committed stores.
REQ-028 A halfword load SHALL extract 16 bits and a byte load 8 bits, then zero- or sign-extend to 32 bits per req_unsigned.
REQ-029 A word load SHALL ignore req_unsigned.
REQ-030 A misaligned access SHALL be one where (word and addr[1:0]!=0), (halfword and addr[0]=1), or size=11.
REQ-031 A misaligned access SHALL take the full latency, write nothing, and return rdata=0 with resp_err=1.
REQ-032 A store response SHALL return rdata=0 and resp_err=0 when aligned.
REQ-033 Back-to-back requests: a new request SHALL be accepted from IDLE in the cycle after RESP, so the minimum initiation interval is LATENCY+2 cycles.

Reset
REQ-034 On rst=1 at an edge, state SHALL go to IDLE and cnt, the latched request, rdata, resp_valid and resp_err SHALL all clear to 0.
REQ-035 stall SHALL read 0 during reset, regardless of req_valid.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 If rst is asserted while in WAIT, before the commit edge, the pending store SHALL NOT be written and no resp_valid SHALL be issued.
REQ-038 rst SHALL take priority over every transition in the same cycle.

Verification
REQ-039 LATENCY=2: word store of 0xDEADBEEF to 0x10, then word load from 0x10 -> rdata=0xDEADBEEF; resp_valid high exactly in cycle T+3; stall high for cycles T..T+2.
REQ-040 Byte stores of 0x80 to 0x21 and 0x7F to 0x22 over word 0x0000_0000, then signed byte load from 0x21 -> 0xFFFFFF80; unsigned -> 0x00000080; word load -> 0x007F8000.
REQ-041 Halfword store of 0xA5A5 to 0x32, then signed halfword load from 0x32 -> 0xFFFFA5A5; halfword load from 0x30 -> previous contents of lanes 0-1, unchanged.
REQ-042 Word load at 0x13, halfword store at 0x15, and size=11 -> each gives resp_err=1, rdata=0, full latency; a subsequent word load at 0x14 shows memory unchanged.
REQ-043 Start a store to 0x40, pulse rst in the WAIT cycle -> no resp_valid, stall=0 after reset, and a later load from 0x40 returns the old value.
REQ-044 DEPTH_WORDS=1024, store 0x12345678 to 0x1000 -> a load from 0x0 returns 0x12345678 (wrap-around).
